fact_sched: RTL and testbench

- Sequencer and round-robin arbiter that shares one factorial accelerator between NREQ requesters.
- Accepts a 4-bit n from a requester, issues a single-cycle Go to the accelerator, then waits for Done or Err.
- Returns the 32-bit result, or an error, to that requester through a valid/ready response channel.
- Watchdog aborts a hung job. Sits between the memory-mapped requester ports and the accelerator instance.

---
 rtl/fact_pkg.sv | 15 +
 rtl/fact_rr_arb.sv | 32 +++
 rtl/fact_sched.sv | 139 +++++++++++++
 tb/tb_fact_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial accelerator scheduler.
package fact_pkg;

  localparam int FACT_NW    = 4;   // operand width
  localparam int FACT_RW    = 32;  // result width
  localparam int FACT_MAX_N = 12;  // largest n whose factorial fits in FACT_RW bits

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/fact_rr_arb.sv
// Combinational round-robin picker: first asserted request at or above ptr_i,
// wrapping from NREQ-1 back to 0.
module fact_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  id_o
);

  // Scan from farthest to nearest so the candidate closest to the pointer wins last.
  always_comb begin
    int unsigned idx;
    logic [IDW-1:0] sel;
    gnt_o = '0;
    id_o  = '0;
    idx   = 0;
    sel   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IDW'(idx);
      if (req_i[sel]) begin
        gnt_o = NREQ'(1) << sel;
        id_o  = sel;
      end
    end
  end

endmodule

// File: rtl/fact_sched.sv
// Shares one factorial accelerator between NREQ requesters: round-robin grant,
// single-cycle launch, watchdog-guarded wait, valid/ready response.
module fact_sched
  import fact_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic                  Clk_i,
  input  logic                  Rst_ni,
  input  logic [NREQ-1:0]       Req_i,
  input  logic [FACT_NW*NREQ-1:0] ReqN_i,
  output logic [NREQ-1:0]       Gnt_o,
  output logic                  AccGo_o,
  output logic [FACT_NW-1:0]    AccN_o,
  output logic                  AccAbort_o,
  input  logic                  AccDone_i,
  input  logic                  AccErr_i,
  input  logic [FACT_RW-1:0]    AccNf_i,
  output logic                  RspValid_o,
  input  logic                  RspReady_i,
  output logic [IDW-1:0]        RspId_o,
  output logic [FACT_RW-1:0]    RspData_o,
  output logic                  RspErr_o,
  output logic                  RspTmo_o,
  output logic                  Busy_o,
  output logic [15:0]           JobCnt_o
);

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, id_q, rsp_id_q;
  logic [FACT_NW-1:0]   n_q, sel_n;
  logic [TW-1:0]        wdog_q;
  logic                 abort_q, rsp_err_q, rsp_tmo_q;
  logic [FACT_RW-1:0]   rsp_data_q;
  logic [15:0]          jobcnt_q;
  logic [NREQ-1:0]      arb_gnt;
  logic [IDW-1:0]       arb_id;
  logic                 tmo, finish;

  fact_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i (Req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .id_o  (arb_id)
  );

  // Operand of the requester the arbiter is currently picking.
  always_comb begin
    sel_n = '0;
    for (int i = 0; i < NREQ; i++)
      if (arb_id == IDW'(i)) sel_n = ReqN_i[i*FACT_NW +: FACT_NW];
  end

  // Completion beats a same-cycle timeout; error beats done.
  assign tmo    = (state_q == ST_BUSY) && !AccErr_i && !AccDone_i &&
                  (wdog_q == TW'(TIMEOUT - 1));
  assign finish = AccErr_i || AccDone_i || tmo;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|Req_i) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_BUSY;
      ST_BUSY:   if (finish) state_d = ST_RESP;
      ST_RESP:   if (RspReady_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Job, watchdog and response registers.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      ptr_q      <= '0;
      id_q       <= '0;
      n_q        <= '0;
      wdog_q     <= '0;
      abort_q    <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_tmo_q  <= 1'b0;
      jobcnt_q   <= '0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (|Req_i) begin
          id_q <= arb_id;
          n_q  <= sel_n;
        end
        ST_LAUNCH: wdog_q <= '0;
        ST_BUSY: begin
          wdog_q <= wdog_q + 1'b1;
          if (AccErr_i) begin
            rsp_err_q  <= 1'b1;
            rsp_data_q <= '0;
          end else if (AccDone_i) begin
            rsp_data_q <= AccNf_i;
          end else if (tmo) begin
            abort_q    <= 1'b1;
            rsp_tmo_q  <= 1'b1;
            rsp_data_q <= '0;
          end
          if (finish) rsp_id_q <= id_q;
        end
        ST_RESP: if (RspReady_i) begin
          jobcnt_q  <= jobcnt_q + 16'd1;
          ptr_q     <= (id_q == IDW'(NREQ - 1)) ? '0 : IDW'(id_q + 1'b1);
          rsp_err_q <= 1'b0;
          rsp_tmo_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Grant is only offered in IDLE and is forced low while reset is held.
  assign Gnt_o      = (state_q == ST_IDLE && Rst_ni) ? arb_gnt : '0;
  assign AccGo_o    = (state_q == ST_LAUNCH);
  assign AccN_o     = n_q;
  assign AccAbort_o = abort_q;
  assign RspValid_o = (state_q == ST_RESP);
  assign RspId_o    = rsp_id_q;
  assign RspData_o  = rsp_data_q;
  assign RspErr_o   = rsp_err_q;
  assign RspTmo_o   = rsp_tmo_q;
  assign Busy_o     = (state_q != ST_IDLE);
  assign JobCnt_o   = jobcnt_q;

endmodule

// File: tb/tb_fact_sched.sv
// Directed bench for fact_sched: reset, single job, fairness, error priority,
// watchdog, backpressure and reset during a job.
module tb_fact_sched;

  localparam int NREQ = 4, IDW = 2, TIMEOUT = 64, TW = 7;

  logic             Clk_i = 0, Rst_ni = 0;
  logic [NREQ-1:0]  Req_i = '0;
  logic [4*NREQ-1:0] ReqN_i = '0;
  logic [NREQ-1:0]  Gnt_o;
  logic             AccGo_o, AccAbort_o;
  logic [3:0]       AccN_o;
  logic             AccDone_i = 0, AccErr_i = 0;
  logic [31:0]      AccNf_i = '0;
  logic             RspValid_o, RspReady_i = 0;
  logic [IDW-1:0]   RspId_o;
  logic [31:0]      RspData_o;
  logic             RspErr_o, RspTmo_o, Busy_o;
  logic [15:0]      JobCnt_o;

  int checks = 0, errors = 0;
  logic [15:0] jc = '0;

  fact_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .Clk_i(Clk_i), .Rst_ni(Rst_ni), .Req_i(Req_i), .ReqN_i(ReqN_i), .Gnt_o(Gnt_o),
    .AccGo_o(AccGo_o), .AccN_o(AccN_o), .AccAbort_o(AccAbort_o),
    .AccDone_i(AccDone_i), .AccErr_i(AccErr_i), .AccNf_i(AccNf_i),
    .RspValid_o(RspValid_o), .RspReady_i(RspReady_i), .RspId_o(RspId_o),
    .RspData_o(RspData_o), .RspErr_o(RspErr_o), .RspTmo_o(RspTmo_o),
    .Busy_o(Busy_o), .JobCnt_o(JobCnt_o)
  );

  always #5 Clk_i = ~Clk_i;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    Rst_ni = 0; Req_i = '0; AccDone_i = 0; AccErr_i = 0; RspReady_i = 0;
    @(negedge Clk_i); @(negedge Clk_i);
    Rst_ni = 1; jc = '0;
    @(negedge Clk_i);
  endtask

  // Runs one job from an IDLE negedge; returns what the DUT showed along the way.
  task automatic do_job(input logic [3:0] req, input logic [15:0] ns, input int lat,
                        input logic done, input logic err, input logic [31:0] nf,
                        output logic [3:0] gnt, output logic go, output logic [3:0] accn,
                        output logic vld, output logic [1:0] id, output logic [31:0] data,
                        output logic rerr, output logic rtmo, output logic abort_seen,
                        output int wait_cyc);
    Req_i = req; ReqN_i = ns; #1;
    gnt = Gnt_o; abort_seen = 0;
    @(negedge Clk_i);
    go = AccGo_o; accn = AccN_o; Req_i = '0;
    @(negedge Clk_i);
    repeat (lat) begin abort_seen |= AccAbort_o; @(negedge Clk_i); end
    AccDone_i = done; AccErr_i = err; AccNf_i = nf;
    wait_cyc = 0;
    do begin
      @(negedge Clk_i);
      AccDone_i = 0; AccErr_i = 0; wait_cyc++;
      abort_seen |= AccAbort_o;
    end while (!RspValid_o && wait_cyc < 300);
    vld = RspValid_o; id = RspId_o; data = RspData_o; rerr = RspErr_o; rtmo = RspTmo_o;
    RspReady_i = 1; @(negedge Clk_i); RspReady_i = 0;
    if (vld) jc++;
  endtask

  task automatic test_reset();
    Rst_ni = 0; Req_i = 4'b1111; #1;
    checks++;
    if ({Gnt_o, AccGo_o, AccN_o, AccAbort_o, RspValid_o, RspId_o, RspData_o, RspErr_o,
         RspTmo_o, Busy_o, JobCnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b go=%b n=%0d ab=%b v=%b id=%0d d=%0d e=%b t=%b busy=%b cnt=%0d, all required 0",
               Gnt_o, AccGo_o, AccN_o, AccAbort_o, RspValid_o, RspId_o, RspData_o, RspErr_o, RspTmo_o, Busy_o, JobCnt_o);
    end
    apply_reset();
    checks++;
    if (Busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b exp 0", Busy_o); end
  endtask

  task automatic test_single();
    logic [3:0] g, an; logic go, v, e, t, ab; logic [1:0] id; logic [31:0] d; int w;
    do_job(4'b0001, 16'h0005, 5, 1, 0, 32'd120, g, go, an, v, id, d, e, t, ab, w);
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b exp 0001", g); end
    checks++;
    if (go !== 1'b1 || an !== 4'd5) begin errors++; $display("FAIL single_go: go=%b n=%0d exp 1/5", go, an); end
    checks++;
    if (v !== 1'b1 || id !== 2'd0 || d !== 32'd120 || e !== 1'b0 || t !== 1'b0) begin
      errors++; $display("FAIL single_rsp: v=%b id=%0d d=%0d e=%b t=%b exp 1/0/120/0/0", v, id, d, e, t);
    end
    checks++;
    if (JobCnt_o !== 16'd1 || RspValid_o !== 1'b0) begin
      errors++; $display("FAIL single_cnt: cnt=%0d v=%b exp 1/0", JobCnt_o, RspValid_o);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] g, an; logic go, v, e, t, ab; logic [1:0] id; logic [31:0] d; int w;
    logic [3:0] exp_g [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
    logic [3:0] reqs  [7] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1100, 4'b1100};
    apply_reset();
    for (int j = 0; j < 7; j++) begin
      do_job(reqs[j], 16'h4321, 0, 1, 0, 32'(j + 100), g, go, an, v, id, d, e, t, ab, w);
      checks++;
      if (g !== exp_g[j] || d !== 32'(j + 100)) begin
        errors++; $display("FAIL rr_job%0d: gnt=%b d=%0d exp %b/%0d", j, g, d, exp_g[j], j + 100);
      end
      if (j == 0) begin
        checks++;
        if (w !== 1) begin errors++; $display("FAIL min_latency: resp after %0d busy cycles exp 1", w); end
      end
    end
    checks++;
    if (JobCnt_o !== 16'd7) begin errors++; $display("FAIL rr_cnt: cnt=%0d exp 7", JobCnt_o); end
  endtask

  task automatic test_err_priority();
    logic [3:0] g, an; logic go, v, e, t, ab; logic [1:0] id; logic [31:0] d; int w;
    do_job(4'b0100, 16'h0D00, 2, 1, 1, 32'hDEAD, g, go, an, v, id, d, e, t, ab, w);
    checks++;
    if (g !== 4'b0100 || an !== 4'd13) begin errors++; $display("FAIL err_launch: gnt=%b n=%0d exp 0100/13", g, an); end
    checks++;
    if (v !== 1'b1 || id !== 2'd2 || d !== 32'd0 || e !== 1'b1 || t !== 1'b0) begin
      errors++; $display("FAIL err_rsp: v=%b id=%0d d=%0h e=%b t=%b exp 1/2/0/1/0", v, id, d, e, t);
    end
  endtask

  task automatic test_watchdog();
    logic [3:0] g, an; logic go, v, e, t, ab; logic [1:0] id; logic [31:0] d; int w, cnt;
    Req_i = 4'b1000; ReqN_i = 16'h7000; #1;
    checks++;
    if (Gnt_o !== 4'b1000) begin errors++; $display("FAIL wd_gnt: got %b exp 1000", Gnt_o); end
    @(negedge Clk_i); Req_i = '0;
    @(negedge Clk_i);
    cnt = 0;
    while (!AccAbort_o && cnt < 200) begin @(negedge Clk_i); cnt++; end
    checks++;
    if (cnt !== TIMEOUT) begin errors++; $display("FAIL wd_abort_time: abort after %0d cycles exp %0d", cnt, TIMEOUT); end
    checks++;
    if (RspValid_o !== 1'b1 || RspTmo_o !== 1'b1 || RspErr_o !== 1'b0 || RspData_o !== 32'd0 || RspId_o !== 2'd3) begin
      errors++; $display("FAIL wd_rsp: v=%b t=%b e=%b d=%0d id=%0d exp 1/1/0/0/3", RspValid_o, RspTmo_o, RspErr_o, RspData_o, RspId_o);
    end
    @(negedge Clk_i);
    checks++;
    if (AccAbort_o !== 1'b0 || RspValid_o !== 1'b1) begin
      errors++; $display("FAIL wd_pulse: abort=%b v=%b exp 0/1", AccAbort_o, RspValid_o);
    end
    RspReady_i = 1; @(negedge Clk_i); RspReady_i = 0; jc++;
    checks++;
    if (RspTmo_o !== 1'b0 || JobCnt_o !== jc) begin
      errors++; $display("FAIL wd_accept: t=%b cnt=%0d exp 0/%0d", RspTmo_o, JobCnt_o, jc);
    end
    // Done in the watchdog's last cycle is a normal completion.
    do_job(4'b0001, 16'h0006, TIMEOUT - 1, 1, 0, 32'd42, g, go, an, v, id, d, e, t, ab, w);
    checks++;
    if (g !== 4'b0001 || v !== 1'b1 || d !== 32'd42 || t !== 1'b0 || e !== 1'b0 || ab !== 1'b0 || w !== 1) begin
      errors++; $display("FAIL wd_race: gnt=%b v=%b d=%0d t=%b e=%b ab=%b w=%0d exp 0001/1/42/0/0/0/1", g, v, d, t, e, ab, w);
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    Req_i = 4'b0001; ReqN_i = 16'h0043; #1;
    checks++;
    if (Gnt_o !== 4'b0001) begin errors++; $display("FAIL bp_gnt0: got %b exp 0001", Gnt_o); end
    @(negedge Clk_i); Req_i = '0;
    @(negedge Clk_i); AccDone_i = 1; AccNf_i = 32'd6;
    @(negedge Clk_i); AccDone_i = 0; Req_i = 4'b0010;
    ok = 1;
    for (int c = 0; c < 10; c++) begin
      if (RspValid_o !== 1'b1 || RspId_o !== 2'd0 || RspData_o !== 32'd6 || Gnt_o !== 4'b0000 ||
          AccGo_o !== 1'b0 || Busy_o !== 1'b1) begin
        ok = 0;
        $display("FAIL bp_hold_c%0d: v=%b id=%0d d=%0d gnt=%b go=%b busy=%b exp 1/0/6/0000/0/1",
                 c, RspValid_o, RspId_o, RspData_o, Gnt_o, AccGo_o, Busy_o);
      end
      @(negedge Clk_i);
    end
    checks++;
    if (!ok) errors++;
    RspReady_i = 1; @(negedge Clk_i); RspReady_i = 0; jc++;
    checks++;
    if (Gnt_o !== 4'b0010 || RspValid_o !== 1'b0 || RspData_o !== 32'd6 || JobCnt_o !== jc) begin
      errors++; $display("FAIL bp_after: gnt=%b v=%b d=%0d cnt=%0d exp 0010/0/6/%0d", Gnt_o, RspValid_o, RspData_o, JobCnt_o, jc);
    end
    @(negedge Clk_i); Req_i = '0;
    checks++;
    if (AccGo_o !== 1'b1 || AccN_o !== 4'd4) begin errors++; $display("FAIL bp_go: go=%b n=%0d exp 1/4", AccGo_o, AccN_o); end
    @(negedge Clk_i); AccDone_i = 1; AccNf_i = 32'd24;
    @(negedge Clk_i); AccDone_i = 0;
    checks++;
    if (RspValid_o !== 1'b1 || RspId_o !== 2'd1 || RspData_o !== 32'd24) begin
      errors++; $display("FAIL bp_job2: v=%b id=%0d d=%0d exp 1/1/24", RspValid_o, RspId_o, RspData_o);
    end
    RspReady_i = 1; @(negedge Clk_i); RspReady_i = 0; jc++;
  endtask

  task automatic test_reset_busy();
    logic [3:0] g, an; logic go, v, e, t, ab; logic [1:0] id; logic [31:0] d; int w;
    logic ok;
    Req_i = 4'b0100; ReqN_i = 16'h0900;
    @(negedge Clk_i); Req_i = '0;
    @(negedge Clk_i); @(negedge Clk_i);
    #2 Rst_ni = 0; Req_i = 4'b1001; #1;
    checks++;
    if ({Gnt_o, AccGo_o, AccN_o, AccAbort_o, RspValid_o, RspId_o, RspData_o, RspErr_o,
         RspTmo_o, Busy_o, JobCnt_o} !== '0) begin
      errors++;
      $display("FAIL rst_busy_out: gnt=%b go=%b n=%0d v=%b id=%0d d=%0d busy=%b cnt=%0d, all required 0",
               Gnt_o, AccGo_o, AccN_o, RspValid_o, RspId_o, RspData_o, Busy_o, JobCnt_o);
    end
    Req_i = '0; jc = '0;
    @(negedge Clk_i); Rst_ni = 1;
    ok = 1;
    repeat (5) begin
      @(negedge Clk_i);
      if (RspValid_o !== 1'b0 || Busy_o !== 1'b0) ok = 0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_no_rsp: v=%b busy=%b exp 0/0", RspValid_o, Busy_o); end
    do_job(4'b1001, 16'h2003, 1, 1, 0, 32'd6, g, go, an, v, id, d, e, t, ab, w);
    checks++;
    if (g !== 4'b0001 || an !== 4'd3 || id !== 2'd0 || d !== 32'd6 || JobCnt_o !== 16'd1) begin
      errors++; $display("FAIL rst_next: gnt=%b n=%0d id=%0d d=%0d cnt=%0d exp 0001/3/0/6/1", g, an, id, d, JobCnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_err_priority();
    test_watchdog();
    test_backpressure();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
